// File: rtl/gerador_permutacao.sv
// Purpose : uniformly random permutation of N indices (0..N-1) by iterative Fisher-Yates shuffle.
// Latency : start sampled at edge 0, N-1 accepting edges, +1 cycle per rejected draw; ready held in DONE.
// Backpr. : none; start is only honoured in IDLE/DONE. Optional GERADOR_PERM_LFSR_EN uses an internal LFSR as draw source.
module gerador_permutacao #(
  parameter int N      = 4,
  parameter int IDX_W  = 2,
  parameter int RAND_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RAND_W-1:0]    entrada,
  output logic [N*IDX_W-1:0]   perm,
  output logic                 ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHUFFLE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [IDX_W-1:0]   arr     [N];
  logic [IDX_W-1:0]   arr_swp [N];
  logic [IDX_W-1:0]   i;
  logic [IDX_W-1:0]   j;
  logic [N*IDX_W-1:0] perm_swp;
  logic               launch;
  logic               accept;
  logic               last;

  // Only the low index bits (and, with the LFSR, the seed bits) are consumed.
  logic               unused_entrada;
  assign unused_entrada = ^entrada;

`ifdef GERADOR_PERM_LFSR_EN
  logic [15:0] lfsr;

  // Galois LFSR: reseeded on every launch (zero seed is replaced), advanced on every shuffle cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (launch) begin
      lfsr <= (entrada[15:0] == 16'h0000) ? 16'hACE1 : entrada[15:0];
    end else if (state == SHUFFLE) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign j = lfsr[IDX_W-1:0];
`else
  assign j = entrada[IDX_W-1:0];
`endif

  // Step decode and the post-swap array/packed image used on an accepted draw.
  always_comb begin
    launch   = start && ((state == IDLE) || (state == DONE));
    accept   = (state == SHUFFLE) && (j <= i);
    last     = accept && (i == IDX_W'(1));
    arr_swp  = arr;
    perm_swp = '0;
    if (accept) begin
      // j == i writes the same element twice, which leaves arr unchanged.
      arr_swp[i] = arr[j];
      arr_swp[j] = arr[i];
    end
    for (int k = 0; k < N; k++) begin
      perm_swp[(N-1-k)*IDX_W +: IDX_W] = arr_swp[k];
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start is ignored while shuffling, re-arms from DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHUFFLE;
      SHUFFLE: if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = SHUFFLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: ready only in DONE, busy only in SHUFFLE.
  always_comb begin
    ready = (state == DONE);
    busy  = (state == SHUFFLE);
  end

  // Shuffle datapath: reload on launch, swap/decrement on accept, publish perm on the final step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i    <= '0;
      perm <= '0;
      for (int k = 0; k < N; k++) begin
        arr[k] <= IDX_W'(k);
      end
    end else if (launch) begin
      i <= IDX_W'(N-1);
      for (int k = 0; k < N; k++) begin
        arr[k] <= IDX_W'(k);
      end
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        arr[k] <= arr_swp[k];
      end
      if (last) begin
        perm <= perm_swp;
      end else begin
        i <= i - IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gerador_permutacao.sv
module tb_gerador_permutacao;

  logic        clock;
  logic        reset;

  logic        start4;
  logic [15:0] entrada4;
  logic [7:0]  perm4;
  logic        ready4;
  logic        busy4;

  logic        start8;
  logic [15:0] entrada8;
  logic [23:0] perm8;
  logic        ready8;
  logic        busy8;

  int          n_assert;
  int          n_fail;
  logic [31:0] sb4 [$];
  logic [31:0] sb8 [$];

  gerador_permutacao #(.N(4), .IDX_W(2), .RAND_W(16)) dut4 (
    .clock   (clock),
    .reset   (reset),
    .start   (start4),
    .entrada (entrada4),
    .perm    (perm4),
    .ready   (ready4),
    .busy    (busy4)
  );

  gerador_permutacao #(.N(8), .IDX_W(3), .RAND_W(16)) dut8 (
    .clock   (clock),
    .reset   (reset),
    .start   (start8),
    .entrada (entrada8),
    .perm    (perm8),
    .ready   (ready8),
    .busy    (busy8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop4(input string tag);
    logic [31:0] e;
    if (sb4.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected <none queued>", tag, perm4);
    end else begin
      e = sb4.pop_front();
      chk(tag, {24'h0, perm4}, e);
    end
  endtask

  task automatic pulse4(input logic [15:0] e);
    entrada4 = e;
    start4   = 1'b1;
    @(negedge clock);
    start4   = 1'b0;
  endtask

  task automatic wait_ready4(output int cnt);
    cnt = 0;
    while (ready4 !== 1'b1 && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
  endtask

  task automatic run8();
    logic [2:0]  m [8];
    logic [2:0]  tmp;
    logic [2:0]  jj;
    logic [15:0] r;
    logic [23:0] exp;
    logic [7:0]  seen;
    logic [31:0] e;
    int          mi;
    int          rej;
    int          cyc;
    bit          done;
    for (int k = 0; k < 8; k++) m[k] = 3'(k);
    mi   = 7;
    rej  = 0;
    cyc  = 0;
    done = 1'b0;
    entrada8 = 16'($urandom);
    start8   = 1'b1;
    @(negedge clock);
    start8   = 1'b0;
    while (!done && cyc < 200) begin
      r = 16'($urandom_range(0, 65535));
      entrada8 = r;
      jj = r[2:0];
      if (int'(jj) <= mi) begin
        tmp = m[mi];
        m[mi] = m[jj];
        m[jj] = tmp;
        if (mi == 1) begin
          done = 1'b1;
          exp = '0;
          for (int k = 0; k < 8; k++) exp[(7-k)*3 +: 3] = m[k];
          sb8.push_back({8'h0, exp});
        end else begin
          mi--;
        end
      end else begin
        rej++;
      end
      @(negedge clock);
      cyc++;
    end
    chk("n8_ready", {31'h0, ready8}, 32'h1);
    chk("n8_cycles", 32'(cyc), 32'(7 + rej));
    seen = '0;
    for (int k = 0; k < 8; k++) seen[perm8[(7-k)*3 +: 3]] = 1'b1;
    chk("n8_valid", {24'h0, seen}, 32'hFF);
    if (sb8.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL n8_perm: observed 0x%0h expected <none queued>", perm8);
    end else begin
      e = sb8.pop_front();
      chk("n8_perm", {8'h0, perm8}, e);
    end
  endtask

  initial begin
    int cnt;
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start4   = 1'b0;
    entrada4 = '0;
    start8   = 1'b0;
    entrada8 = '0;

    // Reset state
    @(negedge clock);
    chk("rst_perm",  {24'h0, perm4}, 32'h0);
    chk("rst_ready", {31'h0, ready4}, 32'h0);
    chk("rst_busy",  {31'h0, busy4}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // 1: entrada=0 -> (1,2,3,0)
    sb4.push_back(32'h6C);
    pulse4(16'h0000);
    chk("t1_busy_run",  {31'h0, busy4}, 32'h1);
    chk("t1_ready_run", {31'h0, ready4}, 32'h0);
    wait_ready4(cnt);
    chk("t1_ready", {31'h0, ready4}, 32'h1);
    chk("t1_lat", 32'(cnt), 32'd3);
    chk("t1_busy_done", {31'h0, busy4}, 32'h0);
    pop4("t1_perm");

    // 2: entrada=1 -> (0,2,3,1), launched from DONE
    sb4.push_back(32'h2D);
    pulse4(16'h0001);
    wait_ready4(cnt);
    chk("t2_ready", {31'h0, ready4}, 32'h1);
    chk("t2_lat", 32'(cnt), 32'd3);
    pop4("t2_perm");

    // 3: entrada=3 rejects after the first step, then entrada=0 finishes -> (1,2,0,3)
    sb4.push_back(32'h63);
    pulse4(16'h0003);
    repeat (5) @(negedge clock);
    chk("t3_busy_stall",  {31'h0, busy4}, 32'h1);
    chk("t3_ready_stall", {31'h0, ready4}, 32'h0);
    entrada4 = 16'h0000;
    wait_ready4(cnt);
    chk("t3_ready", {31'h0, ready4}, 32'h1);
    chk("t3_lat", 32'(cnt), 32'd2);
    pop4("t3_perm");

    // 4: reset mid-shuffle acts immediately
    pulse4(16'h0003);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t4_perm",  {24'h0, perm4}, 32'h0);
    chk("t4_ready", {31'h0, ready4}, 32'h0);
    chk("t4_busy",  {31'h0, busy4}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    sb4.push_back(32'h6C);
    pulse4(16'h0000);
    wait_ready4(cnt);
    chk("t4_ready_after", {31'h0, ready4}, 32'h1);
    chk("t4_lat", 32'(cnt), 32'd3);
    pop4("t4_perm_after");

    // 5: restart from DONE, start pulse mid-shuffle is ignored
    sb4.push_back(32'h2D);
    pulse4(16'h0001);
    chk("t5_ready_drop", {31'h0, ready4}, 32'h0);
    @(negedge clock);
    start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    wait_ready4(cnt);
    chk("t5_ready", {31'h0, ready4}, 32'h1);
    chk("t5_lat", 32'(cnt), 32'd1);
    pop4("t5_perm");

    // 6: N=8 random draws
    @(negedge clock);
    for (int run = 0; run < 1000; run++) begin
      run8();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
